// File: rtl/l1d_cache_pkg.sv
// rtl/l1d_cache_pkg.sv - shared types, field widths and address helpers for l1d_cache
package l1d_cache_types;
  localparam int TAG_W = 24;
  localparam int IDX_W = 3;
  localparam int OFF_W = 5;

  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} l1d_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:IDX_W+OFF_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
    return a[IDX_W+OFF_W-1:OFF_W];
  endfunction

  function automatic logic [2:0] addr_word(input logic [31:0] a);
    return a[OFF_W-1:2];
  endfunction
endpackage

// File: rtl/l1d_cache_way.sv
// rtl/l1d_cache_way.sv - one cache way: valid/dirty/tag/data arrays with combinational read
module l1d_cache_way
  import l1d_cache_types::*;
#(
  parameter int SETS      = 8,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     index,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_W-1:0]     tag,
  output logic [LINE_BITS-1:0] line,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic                 store_en,
  input  logic [2:0]           word,
  input  logic [3:0]           byte_enable,
  input  logic [31:0]          wdata,
  input  logic                 clean_en
);
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = data_q[index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (store_en) begin
      dirty_q[index] <= 1'b1;
    end else if (clean_en) begin
      dirty_q[index] <= 1'b0;
    end
  end

  // Tag and data storage carry no reset; valid_q guards their contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) data_q[index][{word, b[1:0], 3'b000} +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/l1d_cache.sv
// rtl/l1d_cache.sv - two-way write-back write-allocate L1 data cache
module l1d_cache
  import l1d_cache_types::*;
#(
  parameter int SETS      = 8,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmem_read,
  input  logic                 cmem_write,
  input  logic [3:0]           cmem_byte_enable,
  input  logic [31:0]          cmem_address,
  input  logic [31:0]          cmem_wdata,
  output logic                 cmem_resp,
  output logic [31:0]          cmem_rdata,
  output logic                 l1d_hit,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);
  l1d_state_t state, next_state;

  logic [SETS-1:0]  lru;
  logic             miss_flag;
  logic             victim;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_index;

  logic             req;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [2:0]       req_word;
  logic [IDX_W-1:0] way_index;
  logic             unused_addr;

  logic [1:0]           way_valid, way_dirty, hit;
  logic [1:0]           fill_en, store_en, clean_en;
  logic [TAG_W-1:0]     way_tag  [2];
  logic [LINE_BITS-1:0] way_line [2];
  logic                 hw;

  assign req         = cmem_read | cmem_write;
  assign req_tag     = addr_tag(cmem_address);
  assign req_index   = addr_index(cmem_address);
  assign req_word    = addr_word(cmem_address);
  assign unused_addr = ^cmem_address[1:0];
  // While a miss is outstanding the arrays are addressed by the latched miss set.
  assign way_index   = (state == CHECK) ? req_index : miss_index;
  assign hw          = hit[1];

  for (genvar w = 0; w < 2; w++) begin : g_way
    l1d_cache_way #(.SETS(SETS), .LINE_BITS(LINE_BITS)) u_way (
      .clk         (clk),
      .rst_n       (rst_n),
      .index       (way_index),
      .valid       (way_valid[w]),
      .dirty       (way_dirty[w]),
      .tag         (way_tag[w]),
      .line        (way_line[w]),
      .fill_en     (fill_en[w]),
      .fill_tag    (miss_tag),
      .fill_line   (pmem_rdata),
      .store_en    (store_en[w]),
      .word        (req_word),
      .byte_enable (cmem_byte_enable),
      .wdata       (cmem_wdata),
      .clean_en    (clean_en[w])
    );
    assign hit[w] = way_valid[w] && (way_tag[w] == req_tag);
  end

  always_comb begin
    next_state   = state;
    cmem_resp    = 1'b0;
    cmem_rdata   = '0;
    l1d_hit      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    fill_en      = '0;
    store_en     = '0;
    clean_en     = '0;
    case (state)
      CHECK: begin
        if (req && (|hit)) begin
          cmem_resp    = 1'b1;
          l1d_hit      = !miss_flag;
          cmem_rdata   = way_line[hw][{req_word, 5'b00000} +: 32];
          store_en[hw] = cmem_write;
        end else if (req) begin
          next_state = (way_valid[lru[req_index]] && way_dirty[lru[req_index]]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim], miss_index, 5'b00000};
        pmem_wdata   = way_line[victim];
        if (pmem_resp) begin
          clean_en[victim] = 1'b1;
          next_state       = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, miss_index, 5'b00000};
        if (pmem_resp) begin
          fill_en[victim] = 1'b1;
          next_state      = CHECK;
        end
      end
      default: next_state = CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CHECK;
      lru        <= '0;
      miss_flag  <= 1'b0;
      victim     <= 1'b0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      state <= next_state;
      if (state == CHECK) begin
        if (req && (|hit)) begin
          lru[req_index] <= ~hw;
          miss_flag      <= 1'b0;
        end else if (req) begin
          // Sticky until the retried request completes, so it reports as a miss.
          miss_flag  <= 1'b1;
          victim     <= lru[req_index];
          miss_tag   <= req_tag;
          miss_index <= req_index;
        end else begin
          miss_flag <= 1'b0;
        end
      end
    end
  end
endmodule
